// File: rtl/note_seq_pkg.sv
// Shared types and defaults for the note sequencer synth.
// The note table and the top-level sequencer both import this package.
package note_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int DEF_SAMPLE_W   = 18;
  localparam int DEF_PERIOD_W   = 7;
  localparam int DEF_NUM_NOTES  = 8;
  localparam int DEF_ENV_W      = 4;
  localparam int DEF_DELAY_W    = 7;
  localparam int DEFAULT_PERIOD = 48;

  // Largest positive value of a two's complement sample of the given width.
  function automatic int amp_max(input int sample_w);
    return (1 << (sample_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/note_seq_synth_table.sv
// Note period register file.
// One write port and one combinational read port; async reset loads the default period.
module note_table
  import note_seq_pkg::*;
#(
  parameter int NUM_NOTES      = DEF_NUM_NOTES,
  parameter int PERIOD_W       = DEF_PERIOD_W,
  parameter int ADDR_W         = $clog2(NUM_NOTES),
  parameter int DEFAULT_PERIOD = note_seq_pkg::DEFAULT_PERIOD
) (
  input  logic                BIT_CLK,
  input  logic                RST_N,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [PERIOD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [PERIOD_W-1:0] rdata
);

  logic [PERIOD_W-1:0] entries [NUM_NOTES];

  always_ff @(posedge BIT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_NOTES; i++) entries[i] <= PERIOD_W'(DEFAULT_PERIOD);
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/note_seq_synth.sv
// Table-driven square-wave note sequencer with a stepped decay envelope.
// Counters advance on the frame strobe; the sample output is registered.
module note_seq_synth
  import note_seq_pkg::*;
#(
  parameter int SAMPLE_W       = DEF_SAMPLE_W,
  parameter int PERIOD_W       = DEF_PERIOD_W,
  parameter int NUM_NOTES      = DEF_NUM_NOTES,
  parameter int ADDR_W         = $clog2(NUM_NOTES),
  parameter int ENV_W          = DEF_ENV_W,
  parameter int DELAY_W        = DEF_DELAY_W,
  parameter int DEFAULT_PERIOD = note_seq_pkg::DEFAULT_PERIOD
) (
  input  logic                       BIT_CLK,
  input  logic                       RST_N,
  input  logic                       FRAME_SIG,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       LOOP,
  input  logic                       DELAY_LOAD,
  input  logic [DELAY_W-1:0]         DELAY_SCALE_IN,
  input  logic                       TBL_WE,
  input  logic [ADDR_W-1:0]          TBL_ADDR,
  input  logic [PERIOD_W-1:0]        TBL_DATA,
  output logic signed [SAMPLE_W-1:0] WAVE,
  output logic [DELAY_W-1:0]         DELAY_SCALE,
  output logic [ADDR_W-1:0]          NOTE_IDX,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam logic [SAMPLE_W-1:0] AMP_MAX   = SAMPLE_W'(amp_max(SAMPLE_W));
  localparam logic [ADDR_W-1:0]   LAST_NOTE = ADDR_W'(NUM_NOTES - 1);

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] frame_cnt, frame_nxt;
  logic [DELAY_W-1:0]  delay_cnt, delay_nxt;
  logic [ENV_W-1:0]    env, env_nxt;
  logic [ADDR_W-1:0]   note_idx, note_nxt;
  logic [DELAY_W-1:0]  delay_scale;
  logic [SAMPLE_W-1:0] wave_q, wave_nxt, amp;
  logic                busy_q, done_q, done_nxt;
  logic [PERIOD_W-1:0] period, period_eff;

  note_table #(
    .NUM_NOTES     (NUM_NOTES),
    .PERIOD_W      (PERIOD_W),
    .ADDR_W        (ADDR_W),
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_table (
    .BIT_CLK(BIT_CLK),
    .RST_N  (RST_N),
    .we     (TBL_WE),
    .waddr  (TBL_ADDR),
    .wdata  (TBL_DATA),
    .raddr  (note_idx),
    .rdata  (period)
  );

  // A rest (period 0) is timed like a one-frame period.
  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign amp        = AMP_MAX >> env;

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    delay_nxt = delay_cnt;
    env_nxt   = env;
    note_nxt  = note_idx;
    done_nxt  = 1'b0;
    if (STOP || START) begin
      state_nxt = STOP ? IDLE : PLAY;
      frame_nxt = '0;
      delay_nxt = '0;
      env_nxt   = '0;
      note_nxt  = '0;
    end else if (state == PLAY && FRAME_SIG) begin
      // ">=" so a shortened period written mid-note still wraps on the next strobe.
      if (frame_cnt >= period_eff - PERIOD_W'(1)) begin
        frame_nxt = '0;
        if (delay_cnt == delay_scale) begin
          delay_nxt = '0;
          if (env != {ENV_W{1'b1}}) begin
            env_nxt = env + ENV_W'(1);
          end else begin
            env_nxt = '0;
            if (note_idx != LAST_NOTE) begin
              note_nxt = note_idx + ADDR_W'(1);
            end else if (LOOP) begin
              note_nxt = '0;
            end else begin
              state_nxt = IDLE;
              note_nxt  = '0;
              done_nxt  = 1'b1;
            end
          end
        end else begin
          delay_nxt = delay_cnt + DELAY_W'(1);
        end
      end else begin
        frame_nxt = frame_cnt + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    wave_nxt = '0;
    if (state == PLAY && period != '0) begin
      wave_nxt = (frame_cnt >= (period >> 1)) ? amp : -amp;
    end
  end

  always_ff @(posedge BIT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      delay_cnt   <= '0;
      env         <= '0;
      note_idx    <= '0;
      delay_scale <= '0;
      wave_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_nxt;
      delay_cnt <= delay_nxt;
      env       <= env_nxt;
      note_idx  <= note_nxt;
      wave_q    <= wave_nxt;
      busy_q    <= (state_nxt == PLAY);
      done_q    <= done_nxt;
      if (DELAY_LOAD) delay_scale <= DELAY_SCALE_IN;
    end
  end

  assign WAVE        = wave_q;
  assign DELAY_SCALE = delay_scale;
  assign NOTE_IDX    = note_idx;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

endmodule
